ps2_host_tx: RTL and testbench

//   PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the

---
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, LSB-first data, odd parity, stop, ACK check.
// Optional macro PS2_TX_RETRY_EN re-sends the same byte after a NACK or timeout, up to MAX_RETRY extra attempts.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int START_TO_MS = 15,
    parameter int FRAME_TO_MS = 2,
    parameter int MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout,
    output logic       err_nack
);
    localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int START_CYC   = CLK_FREQ_HZ / 1000 * START_TO_MS;
    localparam int FRAME_CYC   = CLK_FREQ_HZ / 1000 * FRAME_TO_MS;
    localparam int MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int TIMER_MAX   = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
    localparam int TW          = $clog2(TIMER_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, INHIBIT, REQ, WAIT_CLK, BITS, ACK, WAIT_IDLE, DONE, ERR
    } state_t;

    state_t          state, next_state;
    logic [1:0]      clk_sync, data_sync;
    logic            clk_prev, clk_s, data_s, fe;
    logic [7:0]      data_q;
    logic            parity_q;
    logic [3:0]      bit_cnt;
    logic [2:0]      bit_idx;
    logic [TW-1:0]   timer;
    logic            nack_q, err_nack_q;
    logic            fail, fail_nack, cur_bit;

`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0]   retry_cnt;
    logic            retry;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fe     = clk_prev & ~clk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A NACK is remembered in ACK but only acted on once the device has released both lines.
    always_comb begin
        next_state = state;
        fail       = 1'b0;
        fail_nack  = 1'b0;
        case (state)
            IDLE:      if (tx_valid) next_state = INHIBIT;
            INHIBIT:   if (timer == TW'(INHIBIT_CYC - 1)) next_state = REQ;
            REQ:       next_state = WAIT_CLK;
            WAIT_CLK:  if (fe) next_state = BITS;
                       else if (timer == TW'(START_CYC - 1)) fail = 1'b1;
            BITS:      if (timer == TW'(FRAME_CYC - 1)) fail = 1'b1;
                       else if (fe && bit_cnt == 4'd9) next_state = ACK;
            ACK:       if (timer == TW'(FRAME_CYC - 1)) fail = 1'b1;
                       else if (fe) next_state = WAIT_IDLE;
            WAIT_IDLE: if (timer == TW'(FRAME_CYC - 1)) fail = 1'b1;
                       else if (clk_s && data_s) begin
                           if (nack_q) begin
                               fail      = 1'b1;
                               fail_nack = 1'b1;
                           end else begin
                               next_state = DONE;
                           end
                       end
            DONE, ERR: next_state = IDLE;
            default:   next_state = IDLE;
        endcase
`ifdef PS2_TX_RETRY_EN
        retry = 1'b0;
        if (fail) begin
            if (int'(retry_cnt) < MAX_RETRY) begin
                retry      = 1'b1;
                next_state = INHIBIT;
            end else begin
                next_state = ERR;
            end
        end
`else
        if (fail) next_state = ERR;
`endif
    end

    // The frame timeout runs uninterrupted from the first falling edge through ACK and WAIT_IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if (state == IDLE ||
                 (next_state != state && next_state != ACK && next_state != WAIT_IDLE))
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_cnt    <= '0;
            nack_q     <= 1'b0;
            err_nack_q <= 1'b0;
        end else begin
            if (state == IDLE && tx_valid) begin
                data_q   <= tx_data;
                parity_q <= ~^tx_data;
            end
            if (next_state == INHIBIT) begin
                bit_cnt <= '0;
                nack_q  <= 1'b0;
            end else if (fe && (state == WAIT_CLK || state == BITS)) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == ACK && fe) nack_q <= data_s;
            if (fail) err_nack_q <= fail_nack;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        retry_cnt <= '0;
        else if (state == IDLE && tx_valid) retry_cnt <= '0;
        else if (retry)                    retry_cnt <= retry_cnt + 1'b1;
    end
`endif

    assign bit_idx = bit_cnt[2:0] - 3'd1;

    always_comb begin
        cur_bit = 1'b1;
        if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) cur_bit = data_q[bit_idx];
        else if (bit_cnt == 4'd9)               cur_bit = parity_q;
        tx_ready    = (state == IDLE);
        busy        = (state != IDLE);
        ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
        ps2_data_oe = (state == REQ) || (state == WAIT_CLK) || (state == BITS && !cur_bit);
        done        = (state == DONE) || (state == ERR);
        ack_ok      = (state == DONE);
        err_timeout = (state == ERR) && !err_nack_q;
        err_nack    = (state == ERR) && err_nack_q;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model; timers scaled by running the DUT at CLK_FREQ_HZ=1 MHz.
// Frame words are {stop, parity, D7..D0, start} as sampled by the device on each rising clock edge.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int CLK_HZ   = 1_000_000;
    localparam int INH_CYC  = 100;
    localparam int START_TO = 15_000;
    localparam int HALF     = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout, err_nack;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0, done_cnt = 0, req_cnt = 0, inh_cnt = 0, req_cyc = 0, done_cyc = 0;
    logic last_ack = 1'b0, last_to = 1'b0, last_nack = 1'b0;
    logic [10:0] frame;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(100), .START_TO_MS(15), .FRAME_TO_MS(2), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(clk_line), .ps2_data_in(data_line), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .ack_ok(ack_ok),
        .err_timeout(err_timeout), .err_nack(err_nack)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle-level monitor: inhibit/request durations, done pulses and their flags.
    always @(negedge clk) begin
        cyc++;
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
        if (ps2_clk_oe && ps2_data_oe) begin
            req_cnt++;
            req_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            last_ack  = ack_ok;
            last_to   = err_timeout;
            last_nack = err_nack;
            checkOutput("flag_onehot", 32'(ack_ok) + 32'(err_timeout) + 32'(err_nack), 32'd1);
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        checkOutput("ready_before_send", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Keyboard model: waits for request-to-send, clocks n_edges falling edges, samples data on the high phase.
    task automatic deviceFrame(input logic ack, input int n_edges, output logic [10:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            checkOutput("req_wait", 32'd0, 32'd1);
            return;
        end
        repeat (HALF / 2) @(negedge clk);
        bits[0] = data_line;
        repeat (HALF / 2) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk = 1'b0;
            if (k == n_edges && n_edges < 11) begin
                repeat (10) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
            if (k <= 10) bits[k] = data_line;
            if (k == 10 && ack) dev_data = 1'b0;
            if (k == 11) dev_data = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    task automatic waitDone(input int start_cnt, input int budget);
        int t;
        t = 0;
        while (done_cnt == start_cnt && t < budget) begin
            @(negedge clk);
            t++;
        end
        checkOutput("done_seen", 32'(done_cnt > start_cnt), 32'd1);
    endtask

    task automatic runAckFrame(input string tag, input logic [7:0] b, input logic [10:0] exp_frame);
        int d0;
        d0 = done_cnt;
        inh_cnt = 0;
        applyStimulus(b);
        deviceFrame(1'b1, 11, frame);
        waitDone(d0, 3000);
        checkOutput({tag, "_frame"}, 32'(frame), 32'(exp_frame));
        checkOutput({tag, "_ack"}, 32'(last_ack), 32'd1);
        checkOutput({tag, "_inhibit"}, inh_cnt, INH_CYC);
        @(negedge clk);
        checkOutput({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        checkOutput("rst_done", {29'd0, done, ack_ok, err_timeout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Device-to-host clocking while idle must not provoke any drive.
        repeat (3) begin
            dev_clk = 1'b0;
            repeat (5) @(negedge clk);
            dev_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        checkOutput("idle_fe_drive", inh_cnt + req_cnt + done_cnt, 32'd0);
        checkOutput("idle_fe_ready", 32'(tx_ready), 32'd1);

        runAckFrame("ed", 8'hED, 11'h7DA);
        runAckFrame("x00", 8'h00, 11'h600);
        checkOutput("x00_parity", 32'(frame[9]), 32'd1);
        runAckFrame("x01", 8'h01, 11'h402);
        checkOutput("x01_parity", 32'(frame[9]), 32'd0);

        // Silent device: ERR follows the full 15 ms WAIT_CLK window that starts the cycle after REQ.
        d0 = done_cnt;
        req_cnt = 0;
        applyStimulus(8'hFF);
        waitDone(d0, 60_000);
        checkOutput("to_flag", 32'(last_to), 32'd1);
        checkOutput("to_ack", 32'(last_ack), 32'd0);
        checkOutput("to_latency", done_cyc - req_cyc, START_TO + 1);
        checkOutput("to_attempts", req_cnt, ATTEMPTS);
        @(negedge clk);
        checkOutput("to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

        d0 = done_cnt;
        req_cnt = 0;
        applyStimulus(8'hF4);
        for (int a = 0; a < ATTEMPTS; a++) deviceFrame(1'b0, 11, frame);
        waitDone(d0, 3000);
        checkOutput("nack_flag", 32'(last_nack), 32'd1);
        checkOutput("nack_ack", 32'(last_ack), 32'd0);
        checkOutput("nack_attempts", req_cnt, ATTEMPTS);
        checkOutput("nack_frame", 32'(frame), 32'h5E8);
        checkOutput("nack_done_count", done_cnt - d0, 32'd1);

        // Reset after the fifth falling edge: D4 of 0xED is 0, so data is being pulled low.
        d0 = done_cnt;
        applyStimulus(8'hED);
        deviceFrame(1'b1, 5, frame);
        checkOutput("mid_d4_drive", 32'(ps2_data_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("mid_rst_ready", 32'(tx_ready), 32'd1);
        checkOutput("mid_rst_nodone", done_cnt, d0);

        // A request while busy must neither replace the byte nor queue a second frame.
        d0 = done_cnt;
        req_cnt = 0;
        applyStimulus(8'hA5);
        repeat (20) @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        deviceFrame(1'b1, 11, frame);
        waitDone(d0, 3000);
        checkOutput("busy_frame", 32'(frame), 32'h74A);
        checkOutput("busy_ack", 32'(last_ack), 32'd1);
        repeat (300) @(negedge clk);
        checkOutput("busy_single_req", req_cnt, 32'd1);
        checkOutput("busy_single_done", done_cnt - d0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule
